// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick responder: FSM states,
// player-word bit positions and the default per-player frame length.
package joy_db15_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Bit positions inside a player word (bit 0 is shifted first).
  localparam int unsigned BIT_R    = 0;
  localparam int unsigned BIT_L    = 1;
  localparam int unsigned BIT_D    = 2;
  localparam int unsigned BIT_U    = 3;
  localparam int unsigned BIT_A    = 4;
  localparam int unsigned BIT_B    = 5;
  localparam int unsigned BIT_C    = 6;
  localparam int unsigned BIT_D_BT = 7;
  localparam int unsigned BIT_E    = 8;
  localparam int unsigned BIT_F    = 9;
  localparam int unsigned BIT_S    = 10;
  localparam int unsigned BIT_COIN = 11;

  localparam int unsigned DEFAULT_BITS_PER_PLAYER = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous input, with a selectable
// reset value so the synchronised level matches the line's idle state.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous level, then re-register it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joy_db15_resp.sv
// DB15 joystick serial responder: emulates the adapter's PISO chain and
// answers JOY_LOAD / JOY_CLK with JOY_DATA, player 1 bit 0 first.
// Optional feature macro: JOY_DB15_RESP_CHAIN_EN adds ser_in as the fill bit.
module joy_db15_resp
  import joy_db15_pkg::*;
#(
  parameter int unsigned BITS_PER_PLAYER = DEFAULT_BITS_PER_PLAYER,
  parameter bit          INVERT          = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        joy_clk_in,
  input  logic        joy_load_in,
`ifdef JOY_DB15_RESP_CHAIN_EN
  input  logic        ser_in,
`endif
  output logic        joy_data_out,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort
);

  localparam int unsigned N  = 2 * BITS_PER_PLAYER;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  logic          clk_s;
  logic          load_s;
  logic          clk_prev;
  logic          clk_rise;
  logic          fill;
  logic [N-1:0]  image;
  logic [N-1:0]  shreg;
  logic [CW-1:0] cnt;
  state_t        state;
  state_t        state_nxt;
  logic          done_set;
  logic          abort_set;
  logic          unused_bits;

  sync2 #(.RST_VAL(1'b0)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (joy_clk_in),
    .q     (clk_s)
  );

  sync2 #(.RST_VAL(1'b1)) u_load_sync (
    .clk   (clk),
    .reset (reset),
    .d     (joy_load_in),
    .q     (load_s)
  );

`ifdef JOY_DB15_RESP_CHAIN_EN
  logic ser_s;

  sync2 #(.RST_VAL(1'b1)) u_ser_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ser_in),
    .q     (ser_s)
  );

  assign fill = ser_s;
`else
  assign fill = 1'b1;
`endif

  assign clk_rise     = clk_s & ~clk_prev;
  assign image        = {joystick2[BITS_PER_PLAYER-1:0], joystick1[BITS_PER_PLAYER-1:0]} ^ {N{INVERT}};
  assign joy_data_out = shreg[0];
  // Player-word bits above the frame length are deliberately ignored.
  assign unused_bits  = ^{joystick1, joystick2};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a low load always wins over a clock rise.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!load_s) state_nxt = ST_LOAD;
      ST_LOAD:  if (load_s)  state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (!load_s)                          state_nxt = ST_LOAD;
        else if (clk_rise && cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE:  if (!load_s) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs and pulse requests decoded from the current state.
  always_comb begin
    busy      = (state == ST_SHIFT);
    done_set  = (state == ST_SHIFT) && load_s && clk_rise && (cnt == CNT_LAST);
    abort_set = (state == ST_SHIFT) && !load_s && (cnt != '0);
  end

  // Shift register, bit counter and registered one-cycle pulses.
  // The load is applied in every state while load_s is low, which covers
  // the entry edge into LOAD as well as the continuous reload inside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '1;
      cnt         <= '0;
      clk_prev    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      clk_prev    <= clk_s;
      frame_done  <= done_set;
      frame_abort <= abort_set;
      if (!load_s) begin
        shreg <= image;
        cnt   <= '0;
      end else if (clk_rise && (state == ST_SHIFT || state == ST_DONE)) begin
        shreg <= {fill, shreg[N-1:1]};
        if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_resp.sv
// Self-checking bench for joy_db15_resp: a 16-bit and a 12-bit instance
// share the JOY_CLK/JOY_LOAD lines and are compared against a bit-level
// reference computed from the player words.
module tb_joy_db15_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] j1a, j2a, j1b, j2b;
  logic        jclk, jload;
  logic        d1, busy1, fd1, fa1;
  logic        d2, busy2, fd2, fa2;

  int checks = 0;
  int errors = 0;
  int done1_cnt = 0, abort1_cnt = 0, done2_cnt = 0, abort2_cnt = 0;
  int done1_base, abort1_base, done2_base, abort2_base;

  always #5 clk = ~clk;

  joy_db15_resp #(.BITS_PER_PLAYER(16), .INVERT(1'b1)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .joystick1    (j1a),
    .joystick2    (j2a),
    .joy_clk_in   (jclk),
    .joy_load_in  (jload),
`ifdef JOY_DB15_RESP_CHAIN_EN
    .ser_in       (1'b1),
`endif
    .joy_data_out (d1),
    .busy         (busy1),
    .frame_done   (fd1),
    .frame_abort  (fa1)
  );

  joy_db15_resp #(.BITS_PER_PLAYER(12), .INVERT(1'b1)) dut12 (
    .clk          (clk),
    .reset        (reset),
    .joystick1    (j1b),
    .joystick2    (j2b),
    .joy_clk_in   (jclk),
    .joy_load_in  (jload),
`ifdef JOY_DB15_RESP_CHAIN_EN
    .ser_in       (1'b1),
`endif
    .joy_data_out (d2),
    .busy         (busy2),
    .frame_done   (fd2),
    .frame_abort  (fa2)
  );

  // Pulse counters for frame_done / frame_abort.
  always @(negedge clk) begin
    if (fd1 === 1'b1) done1_cnt++;
    if (fa1 === 1'b1) abort1_cnt++;
    if (fd2 === 1'b1) done2_cnt++;
    if (fa2 === 1'b1) abort2_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected line level after k rising JOY_CLK edges since the load.
  function automatic logic model_bit(input logic [15:0] p1, input logic [15:0] p2,
                                     input int b, input int k);
    logic [15:0] w;
    logic        pressed;
    if (k >= 2 * b) return 1'b1;
    w       = (k < b) ? p1 : p2;
    pressed = w[k % b];
    return ~pressed;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_frame(input int exp_abort);
    int a1, a2;
    a1 = abort1_cnt;
    a2 = abort2_cnt;
    jload = 1'b0;
    wait_cyc(5);
    jload = 1'b1;
    wait_cyc(5);
    chk("abort16_on_load", abort1_cnt - a1, exp_abort);
    chk("abort12_on_load", abort2_cnt - a2, exp_abort);
    done1_base  = done1_cnt;
    done2_base  = done2_cnt;
    abort1_base = abort1_cnt;
    abort2_base = abort2_cnt;
  endtask

  task automatic rise();
    jclk = 1'b1;
    wait_cyc(5);
    jclk = 1'b0;
    wait_cyc(5);
  endtask

  task automatic check_state(input int k);
    chk("data16",  d1, model_bit(j1a, j2a, 16, k));
    chk("busy16",  busy1, (k < 32) ? 1 : 0);
    chk("done16",  done1_cnt - done1_base, (k >= 32) ? 1 : 0);
    chk("abort16", abort1_cnt - abort1_base, 0);
    chk("data12",  d2, model_bit(j1b, j2b, 12, k));
    chk("busy12",  busy2, (k < 24) ? 1 : 0);
    chk("done12",  done2_cnt - done2_base, (k >= 24) ? 1 : 0);
    chk("abort12", abort2_cnt - abort2_base, 0);
  endtask

  task automatic run_rises(input int from, input int to);
    for (int k = from + 1; k <= to; k++) begin
      rise();
      check_state(k);
    end
  endtask

  initial begin
    reset = 1'b1;
    jclk  = 1'b0;
    jload = 1'b1;
    j1a = 16'h0001; j2a = 16'h8000;
    j1b = 16'h0FFF; j2b = 16'h0000;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);

    chk("reset_data16", d1, 1);
    chk("reset_busy16", busy1, 0);
    chk("reset_done16", fd1, 0);
    chk("reset_abort16", fa1, 0);
    chk("reset_data12", d2, 1);
    chk("reset_busy12", busy2, 0);

    // Directed frame, then five extra clocks past the end.
    load_frame(0);
    check_state(0);
    run_rises(0, 37);

    // Reload after 10 clocks aborts; the new frame restarts at bit 0.
    j1a = 16'($urandom); j2a = 16'($urandom);
    j1b = 16'($urandom); j2b = 16'($urandom);
    load_frame(0);
    check_state(0);
    run_rises(0, 10);
    j1a = 16'($urandom); j2a = 16'($urandom);
    j1b = 16'($urandom); j2b = 16'($urandom);
    load_frame(1);
    check_state(0);
    run_rises(0, 33);

    // Load falling together with a JOY_CLK rise: load wins, no shift.
    j1a = 16'($urandom); j2a = 16'($urandom);
    j1b = 16'($urandom); j2b = 16'($urandom);
    begin
      int a1;
      a1 = abort1_cnt;
      jload = 1'b0;
      jclk  = 1'b1;
      wait_cyc(5);
      jclk = 1'b0;
      wait_cyc(5);
      jload = 1'b1;
      wait_cyc(5);
      chk("abort16_sameedge", abort1_cnt - a1, 0);
    end
    done1_base  = done1_cnt;  done2_base  = done2_cnt;
    abort1_base = abort1_cnt; abort2_base = abort2_cnt;
    check_state(0);
    run_rises(0, 32);

    // Reset in the middle of a frame.
    j1a = 16'($urandom); j2a = 16'($urandom);
    j1b = 16'($urandom); j2b = 16'($urandom);
    load_frame(0);
    run_rises(0, 7);
    begin
      int dc, ac;
      dc = done1_cnt + done2_cnt;
      ac = abort1_cnt + abort2_cnt;
      reset = 1'b1;
      wait_cyc(1);
      reset = 1'b0;
      chk("midreset_data16", d1, 1);
      chk("midreset_busy16", busy1, 0);
      chk("midreset_data12", d2, 1);
      chk("midreset_busy12", busy2, 0);
      wait_cyc(3);
      chk("midreset_pulses", (done1_cnt + done2_cnt - dc) + (abort1_cnt + abort2_cnt - ac), 0);
    end

    // Random full frames.
    for (int f = 0; f < 3; f++) begin
      j1a = 16'($urandom); j2a = 16'($urandom);
      j1b = 16'($urandom); j2b = 16'($urandom);
      load_frame(0);
      check_state(0);
      run_rises(0, 34);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
